// File: rtl/score_disp_pkg.sv
// Shared constants and FSM state type for the score display path.
package score_disp_pkg;

    localparam int unsigned BCD_DIGITS   = 4;
    localparam int unsigned MAX_SCORE    = 9999;
    localparam logic [3:0]  BLANK_NIBBLE = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

endpackage

// File: rtl/score_bcd_conv_add3.sv
// Double-dabble nibble correction: add 3 to any BCD digit of 5 or more.
module bcd_add3 (
    input  logic [3:0] v,
    output logic [3:0] y
);

    always_comb begin
        y = (v >= 4'd5) ? v + 4'd3 : v;
    end

endmodule

// File: rtl/score_bcd_conv.sv
// Sequential binary-to-BCD score converter with load/busy/done handshake.
// Define LZ_BLANK_EN to blank leading zero digits (d3..d1) with 4'hF.
module score_bcd_conv
    import score_disp_pkg::*;
#(
    parameter int unsigned BIN_W   = 14,
    parameter int unsigned SAT_MAX = MAX_SCORE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [BIN_W-1:0] bin_in,
    input  logic             load,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [3:0]       d3,
    output logic [3:0]       d2,
    output logic [3:0]       d1,
    output logic [3:0]       d0
);

    localparam int unsigned CNT_W  = $clog2(BIN_W + 1);
    localparam int unsigned BCD_W  = 4 * BCD_DIGITS;
    localparam bit          SAT_EN = (BIN_W >= 14);
    localparam logic [BIN_W-1:0] SAT_VAL = BIN_W'(SAT_MAX);

    state_t             state_q, state_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [BCD_W-1:0]   bcd_adj;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sat_q, sat_d;
    logic               ovf_q, ovf_d;
    logic               done_q, done_d;
    logic [BCD_W-1:0]   dig_q, dig_d;
    logic               sat_in;

    for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .v (bcd_q[4*g +: 4]),
            .y (bcd_adj[4*g +: 4])
        );
    end

    // Narrow builds cannot represent values above the ceiling, so no clamp.
    assign sat_in = SAT_EN && (bin_in > SAT_VAL);

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        dig_d   = dig_q;
        unique case (state_q)
            IDLE: begin
                if (load) begin
                    bin_d   = sat_in ? SAT_VAL : bin_in;
                    sat_d   = sat_in;
                    bcd_d   = '0;
                    cnt_d   = CNT_W'(BIN_W);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
                cnt_d          = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                dig_d = bcd_q;
`ifdef LZ_BLANK_EN
                begin
                    logic lead;
                    lead = 1'b1;
                    for (int unsigned i = BCD_DIGITS - 1; i > 0; i--) begin
                        if (lead && (bcd_q[4*i +: 4] == 4'd0)) begin
                            dig_d[4*i +: 4] = BLANK_NIBBLE;
                        end else begin
                            lead = 1'b0;
                        end
                    end
                end
`endif
                ovf_d   = sat_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            dig_q   <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            dig_q   <= dig_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign ovf  = ovf_q;
    assign d3   = dig_q[15:12];
    assign d2   = dig_q[11:8];
    assign d1   = dig_q[7:4];
    assign d0   = dig_q[3:0];

endmodule

// File: tb/tb_score_bcd_conv.sv
// Scoreboard bench for score_bcd_conv: a cycle model predicts busy/done and
// queues expected digits at each acceptance, popped when done is due.
module tb_score_bcd_conv;

    localparam int unsigned BIN_W = 14;
    localparam int unsigned LAT   = BIN_W + 1;

    logic             clk;
    logic             rst;
    logic [BIN_W-1:0] bin_in;
    logic             load;
    logic             busy;
    logic             done;
    logic             ovf;
    logic [3:0]       d3, d2, d1, d0;

    score_bcd_conv #(.BIN_W(BIN_W), .SAT_MAX(9999)) dut (
        .clk    (clk),
        .rst    (rst),
        .bin_in (bin_in),
        .load   (load),
        .busy   (busy),
        .done   (done),
        .ovf    (ovf),
        .d3     (d3),
        .d2     (d2),
        .d1     (d1),
        .d0     (d0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [15:0] dig;
        logic        ovf;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] last_dig;
    logic        last_ovf;
    int unsigned busy_left;
    logic        exp_done;
    logic        prev_done;
    logic        started;
    int unsigned n_done;

    function automatic exp_t model(input int unsigned v);
        exp_t        e;
        int unsigned s;
        logic [3:0]  dg[4];
        s = (v > 9999) ? 9999 : v;
        dg[3] = 4'(s / 1000);
        dg[2] = 4'((s / 100) % 10);
        dg[1] = 4'((s / 10) % 10);
        dg[0] = 4'(s % 10);
`ifdef LZ_BLANK_EN
        if (dg[3] == 4'd0) begin
            dg[3] = 4'hF;
            if (dg[2] == 4'd0) begin
                dg[2] = 4'hF;
                if (dg[1] == 4'd0) dg[1] = 4'hF;
            end
        end
`endif
        e.dig = {dg[3], dg[2], dg[1], dg[0]};
        e.ovf = (v > 9999);
        return e;
    endfunction

    // Inputs only change 1ns after a posedge, so at the negedge they already
    // hold the values the next edge will sample.
    always @(negedge clk) begin
        if (started) begin
            check("busy", busy, (busy_left > 0));
            check("done", done, exp_done);
            check("done_twice", done && prev_done, 0);
            if (exp_done) begin
                if (sb_q.size() == 0) begin
                    check("sb_empty_on_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    last_dig = e.dig;
                    last_ovf = e.ovf;
                    n_done++;
                end
            end
            check("digits", {d3, d2, d1, d0}, last_dig);
            check("ovf", ovf, last_ovf);
            prev_done = done;
        end
        exp_done = 1'b0;
        if (rst) begin
            busy_left = 0;
            last_dig  = '0;
            last_ovf  = 1'b0;
            sb_q.delete();
        end else if (busy_left == 0) begin
            if (load) begin
                sb_q.push_back(model(int'(bin_in)));
                busy_left = LAT;
            end
        end else begin
            busy_left--;
            if (busy_left == 0) exp_done = 1'b1;
        end
    end

    task automatic cycles(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_load(input int unsigned v);
        load   = 1'b1;
        bin_in = BIN_W'(v);
        cycles(1);
        load   = 1'b0;
        bin_in = BIN_W'($urandom);
    endtask

    initial begin
        int unsigned n_before;
        rst       = 1'b1;
        load      = 1'b0;
        bin_in    = '0;
        busy_left = 0;
        exp_done  = 1'b0;
        prev_done = 1'b0;
        started   = 1'b0;
        last_dig  = '0;
        last_ovf  = 1'b0;
        n_done    = 0;
        @(posedge clk);
        #1;
        started = 1'b1;
        cycles(2);
        rst = 1'b0;
        cycles(1);

        do_load(0);
        cycles(16);
        do_load(1234);
        cycles(16);
        do_load(12000);
        cycles(16);
        do_load(42);
        cycles(16);

        // Load arriving mid-conversion must be dropped.
        do_load(500);
        cycles(4);
        load   = 1'b1;
        bin_in = BIN_W'(777);
        cycles(1);
        load   = 1'b0;
        cycles(12);
        do_load(777);
        cycles(16);

        // Reset mid-conversion aborts with no done pulse.
        do_load(9999);
        cycles(7);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        cycles(3);
        do_load(3);
        cycles(16);

        // Continuous load: back-to-back acceptances every LAT+1 edges.
        n_before = n_done;
        load = 1'b1;
        for (int unsigned i = 0; i < 64; i++) begin
            bin_in = BIN_W'(9990 + i);
            cycles(1);
        end
        load = 1'b0;
        cycles(20);
        check("stream_done_count", n_done - n_before, 4);
        check("sb_drained", sb_q.size(), 0);
        check("total_done_count", n_done, 11);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/score_bcd_conv.md
Name: score_bcd_conv

Overview:
Converts the binary game score into four BCD digit nibbles for the seven-segment scan multiplexer downstream. It uses a sequential double-dabble engine (shift-and-add-3) with a load/busy/done handshake. Digit outputs update atomically on completion, so the display never shows a half-converted value. It sits between the score counter and the display mux, and drives the mux's d3..d0 inputs.

Parameters:
BIN_W, 14, width of binary input; 14 bits covers 0..9999; legal range 4..16
SAT_MAX, 9999, saturation ceiling for the input value

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
bin_in  input  BIN_W  binary score, sampled only on an accepted load
load  input  1  request conversion; accepted when load=1 and busy=0
busy  output  1  high while a conversion is in progress (state != IDLE)
done  output  1  one-cycle pulse when new digits become valid
ovf  output  1  registered with the digits; 1 if the last accepted bin_in exceeded SAT_MAX
d3  output  4  thousands digit (BCD, or 4'hF when blanked)
d2  output  4  hundreds digit
d1  output  4  tens digit
d0  output  4  ones digit (never blanked)

Behaviour:
- Reset (synchronous, highest priority): state=IDLE; busy=0, done=0, ovf=0, d3..d0=4'd0; shift and counter registers cleared. Reset mid-conversion aborts the conversion, with no done pulse.
- FSM states:
  - IDLE:
    - If load is asserted, capture min(bin_in, SAT_MAX) into the binary shift register.
    - Capture the saturation flag internally.
    - Clear the 16-bit BCD accumulator, set cnt=BIN_W, and go to SHIFT.
    - If load is not asserted, stay in IDLE.
  - SHIFT: each cycle, apply add-3 to each BCD nibble that is >=5. Then shift {bcd,bin} left by 1. Decrement cnt. When cnt reaches 1 on this edge (last shift), go to DONE.
  - DONE: register the BCD accumulator into d3..d0 and the flag into ovf; set done=1 for the next cycle; go to IDLE.
- Timing: load accepted at edge E0; shifts occur at E1..E_BIN_W; outputs and done update at E_BIN_W+1.
  - With BIN_W=14, done is high during the cycle following the 15th edge after acceptance.
  - busy is 1 from after E0 until after E_BIN_W+1.
  - Earliest next acceptance is E_BIN_W+2.
- load while busy=1 is ignored, not queued. bin_in is don't-care except on the accepting edge.
- d3..d0 and ovf hold their previous values throughout a conversion.
- done is never asserted for two consecutive cycles.
- Width rules: BCD accumulator is 16 bits. Saturation compares at BIN_W width. When BIN_W<14 the saturation path is statically false.
- Counter width is clog2(BIN_W+1).

Optional Feature:
Macro LZ_BLANK_EN.
- Defined: on the DONE edge, leading zero digits among d3, d2, d1 are replaced by 4'hF (blank code), scanning from d3 downward and stopping at the first nonzero digit. d0 is always numeric. Example: 7 gives F,F,F,7; 105 gives F,1,0,5; 0 gives F,F,F,0.
- Undefined: digits are always numeric (7 gives 0,0,0,7).
- Latency is identical either way.

Decomposition:
- Package score_disp_pkg: BCD_DIGITS=4, MAX_SCORE=9999, BLANK_NIBBLE=4'hF, state enum (IDLE, SHIFT, DONE).
- One natural sub-module: bcd_add3, a combinational nibble correction (v>=5 ? v+3 : v), instantiated four times.
- The FSM, shift registers and blanking logic remain in score_bcd_conv.

Test Plan:
1. Reset, then load bin_in=0 → done after 15 edges; digits 0,0,0,0 (F,F,F,0 with LZ_BLANK_EN); ovf=0.
2. Load 1234 → busy for 15 cycles; d3..d0 hold old values until done; then 1,2,3,4; exactly one done pulse.
3. Load 12000 → digits 9,9,9,9; ovf=1. Next load 42 → 0,0,4,2 (F,F,4,2 with macro); ovf=0.
4. Load 500, then assert load with 777 on cycle 5 of busy → 777 is ignored; result 0,5,0,0 (F,5,0,0 with macro). Load 777 again after done → 0,7,7,7.
5. Load 9999, assert rst at cycle 8 → no done; digits 0,0,0,0; busy=0 the next cycle. Load 3 → 0,0,0,3.
6. Hold load high continuously with incrementing values → acceptances exactly every 16 edges; each done matches the value sampled at its acceptance.
